// File: rtl/mux_digit_scanner.sv
// Multiplexed 8-digit 7-segment scanner with per-slot blanking gap.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module mux_digit_scanner #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_DIGITS   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       WE,
  input  logic [2:0] WADDR,
  input  logic [3:0] WDATA,
  input  logic       WDP,
  output logic [7:0] DIGIT_EN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [2:0] SCAN_IDX,
  output logic       FRAME_DONE
);

  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] BC = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SC = CW'(PRESCALE - BLANK_CYCLES);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;
  logic          show;
  logic [3:0]    dig_q [8];
  logic [7:0]    dpm_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic          lz_b;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] v);
    unique case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      4'hF: return 7'h71;
    endcase
  endfunction

  // cnt_q counts cycles already emitted in the current phase;
  // outputs are registered for the cycle being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    en_d    = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    fd_d    = 1'b0;
    show    = 1'b0;
    if (!ENABLE) begin
      state_d = S_BLANK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_BLANK: begin
          if (cnt_q < BC) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = S_SHOW;
            cnt_d   = CW'(1);
            show    = 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q < SC) begin
            cnt_d = cnt_q + CW'(1);
            show  = 1'b1;
          end else begin
            idx_d = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
            fd_d  = (idx_q == LAST);
            cnt_d = CW'(1);
            if (BC == '0) begin
              state_d = S_SHOW;
              show    = 1'b1;
            end else begin
              state_d = S_BLANK;
            end
          end
        end
      endcase
    end
`ifdef LEADING_ZERO_BLANK_EN
    lz_b = (idx_d != 3'd0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_d) && dig_q[j] != 4'h0) lz_b = 1'b0;
    end
`endif
    if (show) begin
      en_d  = 8'd1 << idx_d;
      seg_d = seg7(dig_q[idx_d]);
      dp_d  = dpm_q[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_b) seg_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      fd_q    <= 1'b0;
      dpm_q   <= '0;
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
      if (WE && int'(WADDR) < NUM_DIGITS) begin
        dig_q[WADDR] <= WDATA;
        dpm_q[WADDR] <= WDP;
      end
    end
  end

  assign DIGIT_EN   = en_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign SCAN_IDX   = idx_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_mux_digit_scanner.sv
// Bench for mux_digit_scanner: vector table, directed corners,
// and random traffic against a slot-arithmetic reference model.
module tb_mux_digit_scanner;

  localparam int P  = 8;
  localparam int BC = 2;
  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic       we  = 1'b0;
  logic [2:0] wa  = '0;
  logic [3:0] wd  = '0;
  logic       wdp = 1'b0;
  logic [7:0] digit_en;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] scan_idx;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_digit_scanner #(
    .PRESCALE(P), .BLANK_CYCLES(BC), .NUM_DIGITS(ND)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(en), .WE(we),
    .WADDR(wa), .WDATA(wd), .WDP(wdp),
    .DIGIT_EN(digit_en), .SEG(seg), .DP(dp),
    .SCAN_IDX(scan_idx), .FRAME_DONE(frame_done)
  );

  logic [6:0] segt [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: k = edges since (re)start, slot phase = k mod P.
  int         k    = 0;
  int         midx = 0;
  logic [3:0] mm  [ND];
  logic       mdp [ND];
  logic [7:0] m_en;
  logic [6:0] m_seg;
  logic       m_dp, m_fd;

  task automatic m_edge();
    if (!rst) begin
      for (int j = 0; j < ND; j++) begin
        mm[j] = '0;
        mdp[j] = 1'b0;
      end
      k = 0;
      midx = 0;
      m_en = '0; m_seg = '0; m_dp = 1'b0; m_fd = 1'b0;
    end else begin
      m_en = '0; m_seg = '0; m_dp = 1'b0; m_fd = 1'b0;
      if (!en) begin
        k = 0;
      end else begin
        if (k > 0 && k % P == 0) begin
          midx = (midx + 1) % ND;
          m_fd = (midx == 0);
        end
        if (k % P >= BC) begin
          m_en  = 8'(1 << midx);
          m_seg = segt[mm[midx]];
          m_dp  = mdp[midx];
`ifdef LEADING_ZERO_BLANK_EN
          if (midx > 0) begin
            bit allz = 1'b1;
            for (int j = midx; j < ND; j++)
              if (mm[j] != 4'h0) allz = 1'b0;
            if (allz) m_seg = '0;
          end
`endif
        end
        k++;
      end
      if (we && int'(wa) < ND) begin
        mm[wa]  = wd;
        mdp[wa] = wdp;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("model", {12'd0, digit_en, seg, dp, scan_idx, frame_done},
        {12'd0, m_en, m_seg, m_dp, 3'(midx), m_fd});
  endtask

  task automatic wait_en(input logic [7:0] v);
    int n = 0;
    while (digit_en !== v && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("timeout_wait_en", 32'(digit_en), 32'(v));
  endtask

  typedef struct {
    logic       r, e, w;
    logic [2:0] a;
    logic [3:0] d;
    logic       p;
    logic [7:0] xen;
    logic [6:0] xseg;
    logic       xdp;
    logic [2:0] xidx;
    logic       xfd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, e, w, input logic [2:0] a, input logic [3:0] d,
    input logic p, input logic [7:0] xen, input logic [6:0] xs,
    input logic [2:0] xi);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.a = a; v.d = d; v.p = p;
    v.xen = xen; v.xseg = xs; v.xdp = 1'b0; v.xidx = xi; v.xfd = 1'b0;
    return v;
  endfunction

  vec_t vt [14];
  int   fd_cnt;

  initial begin
    for (int i = 0; i < 3; i++)
      vt[i] = mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 7'h00, 3'd0);
    vt[3] = mk(1'b1, 1'b1, 1'b1, 3'd1, 4'h2, 1'b0, 8'h00, 7'h00, 3'd0);
    vt[4] = mk(1'b1, 1'b1, 1'b1, 3'd5, 4'h7, 1'b1, 8'h00, 7'h00, 3'd0);
    for (int i = 5; i < 11; i++)
      vt[i] = mk(1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 8'h01, 7'h3F, 3'd0);
    for (int i = 11; i < 13; i++)
      vt[i] = mk(1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 7'h00, 3'd1);
    vt[13] = mk(1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 8'h02, 7'h5B, 3'd1);

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].r; en = vt[i].e; we = vt[i].w;
      wa = vt[i].a; wd = vt[i].d; wdp = vt[i].p;
      step();
      chk($sformatf("vec%0d", i),
          {12'd0, digit_en, seg, dp, scan_idx, frame_done},
          {12'd0, vt[i].xen, vt[i].xseg, vt[i].xdp, vt[i].xidx, vt[i].xfd});
    end
    we = 1'b0;

    // Scan sequence with 1,2,3,A and DP on digit 2
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = 3'(i); wdp = (i == 2);
      wd = (i == 3) ? 4'hA : 4'(i + 1);
      step();
    end
    we = 1'b0; wdp = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        chk("fd_idx0", 32'(scan_idx), 32'd0);
      end
      if (digit_en == 8'h04) chk("dp_slot2", 32'(dp), 32'd1);
      if (digit_en == 8'h08) chk("seg_A", 32'(seg), 32'h77);
    end
    chk("fd_per_64", fd_cnt, 2);

    // Live update of the digit being shown
    wait_en(8'h01);
    wait_en(8'h02);
    we = 1'b1; wa = 3'd1; wd = 4'h9;
    step();
    we = 1'b0;
    chk("live_old", 32'(seg), 32'h5B);
    step();
    chk("live_new", 32'(seg), 32'h6F);
    we = 1'b1; wa = 3'd5; wd = 4'h3;
    step();
    we = 1'b0;
    wait_en(8'h01);
    wait_en(8'h02);
    chk("oob_write", 32'(seg), 32'h6F);

    // Enable dropout on SHOW cycle 3 of slot 2
    wait_en(8'h04);
    step();
    step();
    en = 1'b0;
    step();
    chk("dis_out", {21'd0, digit_en, seg, dp, frame_done}, 32'd0);
    chk("dis_idx", 32'(scan_idx), 32'd2);
    step();
    en = 1'b1;
    for (int i = 0; i < BC; i++) begin
      step();
      chk("reen_blank", 32'(digit_en), 32'd0);
    end
    for (int i = 0; i < P - BC; i++) begin
      step();
      chk("reen_show", 32'(digit_en), 32'h04);
    end
    step();
    chk("reen_end", 32'(digit_en), 32'd0);

    // Leading zero digits {0,0,7,0}
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = 3'(i); wdp = 1'b0;
      wd = (i == 1) ? 4'h7 : 4'h0;
      step();
    end
    we = 1'b0;
    step();
    step();
    wait_en(8'h01);
    chk("lz_d0", 32'(seg), 32'h3F);
    wait_en(8'h02);
    chk("lz_d1", 32'(seg), 32'h07);
    wait_en(8'h04);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2", 32'(seg), 32'h00);
`else
    chk("lz_d2", 32'(seg), 32'h3F);
`endif
    wait_en(8'h08);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d3", 32'(seg), 32'h00);
`else
    chk("lz_d3", 32'(seg), 32'h3F);
`endif

    // Reset mid-frame clears memory and restarts at slot 0
    we = 1'b1; wa = 3'd0; wd = 4'h5;
    step();
    we = 1'b0;
    wait_en(8'h04);
    rst = 1'b0;
    step();
    chk("rst_mid", {20'd0, digit_en, seg, dp, scan_idx, frame_done}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < BC; i++) begin
      step();
      chk("rst_blank", 32'(digit_en), 32'd0);
    end
    step();
    chk("rst_show", {17'd0, digit_en, seg}, {17'd0, 8'h01, 7'h3F});

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 3'($urandom_range(0, 7));
      wd  = 4'($urandom_range(0, 15));
      wdp = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 24) != 0);
      rst = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
